gamma_lut_ctrl: RTL and testbench

//  Runtime-programmable gamma stage with double-buffered 256x8 tables. Host loads the shadow bank,

---
 rtl/gamma_pkg.sv | 12 +
 rtl/gamma_lut_bank.sv | 40 ++++
 rtl/gamma_lut_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_gamma_lut_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gamma_pkg.sv
// Shared definitions for the double-buffered gamma LUT stage.
package gamma_pkg;

    localparam int LUT_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PENDING = 2'd2
    } gamma_state_e;

endpackage

// File: rtl/gamma_lut_bank.sv
// One gamma table bank: 2**DATA_W entries, one synchronous write port and
// three asynchronous read ports (one per colour component).
module gamma_lut_bank
    import gamma_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] raddr_r,
    input  logic [DATA_W-1:0] raddr_g,
    input  logic [DATA_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_r,
    output logic [DATA_W-1:0] rdata_g,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 2 ** DATA_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Table storage; cleared on reset so entries not yet filled read back as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_r = mem_q[raddr_r];
    assign rdata_g = mem_q[raddr_g];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/gamma_lut_ctrl.sv
// Runtime-programmable gamma stage. Pixels map through the active bank while
// the host loads the shadow bank; a commit swaps banks at the next frame start.
module gamma_lut_ctrl
    import gamma_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit INIT_IDENT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic              in_de,
    input  logic [DATA_W-1:0] in_R,
    input  logic [DATA_W-1:0] in_G,
    input  logic [DATA_W-1:0] in_B,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_de,
    output logic [DATA_W-1:0] out_R,
    output logic [DATA_W-1:0] out_G,
    output logic [DATA_W-1:0] out_B,
    input  logic              cfg_wr_en,
    input  logic [DATA_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_commit,
    output logic              cfg_ready,
    output logic              swap_pending,
    output logic              active_bank,
    output logic              init_done
);

    localparam logic [DATA_W-1:0] CNT_LAST = '1;

    gamma_state_e      state_q;
    logic [DATA_W-1:0] cnt_q;
    logic              active_bank_q;
    logic              swap_pending_q;
    logic              cfg_ready_q;
    logic              init_done_q;

    logic              vsync_d, vsync_q;
    logic              vsync_rise;

    logic              fill_en;
    logic              host_wr;
    logic              we0, we1;
    logic [DATA_W-1:0] waddr, wdata;

    logic [DATA_W-1:0] b0_r, b0_g, b0_b;
    logic [DATA_W-1:0] b1_r, b1_g, b1_b;

    logic [DATA_W-1:0] out_r_d, out_g_d, out_b_d;
    logic [DATA_W-1:0] out_r_q, out_g_q, out_b_q;
    logic              out_vsync_d, out_hsync_d, out_de_d;
    logic              out_vsync_q, out_hsync_q, out_de_q;

    assign vsync_rise = in_vsync & ~vsync_q;

    // Control FSM: identity fill, host-load idle, and swap held until frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            cnt_q          <= '0;
            active_bank_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            cfg_ready_q    <= 1'b0;
            init_done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (!INIT_IDENT || (cnt_q == CNT_LAST)) begin
                        state_q     <= ST_IDLE;
                        cfg_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                    // Counter stops at the last index instead of wrapping.
                    if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    // A commit coinciding with a frame start is only accepted;
                    // the swap waits for the following frame start.
                    if (cfg_commit) begin
                        state_q        <= ST_PENDING;
                        cfg_ready_q    <= 1'b0;
                        swap_pending_q <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (vsync_rise) begin
                        state_q        <= ST_IDLE;
                        cfg_ready_q    <= 1'b1;
                        swap_pending_q <= 1'b0;
                        active_bank_q  <= ~active_bank_q;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Write steering: fill hits both banks, host writes only the shadow bank.
    always_comb begin
        fill_en = INIT_IDENT && (state_q == ST_INIT);
        host_wr = (state_q == ST_IDLE) && cfg_wr_en;
        we0     = fill_en || (host_wr && active_bank_q);
        we1     = fill_en || (host_wr && !active_bank_q);
        waddr   = fill_en ? cnt_q : cfg_addr;
        wdata   = fill_en ? cnt_q : cfg_data;
    end

    gamma_lut_bank #(.DATA_W(DATA_W)) u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we0),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_r (in_R),
        .raddr_g (in_G),
        .raddr_b (in_B),
        .rdata_r (b0_r),
        .rdata_g (b0_g),
        .rdata_b (b0_b)
    );

    gamma_lut_bank #(.DATA_W(DATA_W)) u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we1),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_r (in_R),
        .raddr_g (in_G),
        .raddr_b (in_B),
        .rdata_r (b1_r),
        .rdata_g (b1_g),
        .rdata_b (b1_b)
    );

    // Bank select and sync pass-through; the bank flag only changes after the
    // frame-start cycle, so that cycle's pixel still uses the old curve.
    always_comb begin
        vsync_d     = in_vsync;
        out_r_d     = active_bank_q ? b1_r : b0_r;
        out_g_d     = active_bank_q ? b1_g : b0_g;
        out_b_d     = active_bank_q ? b1_b : b0_b;
        out_vsync_d = in_vsync;
        out_hsync_d = in_hsync;
        out_de_d    = in_de;
    end

    // Output and edge-detect registers: one cycle of latency on every path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
            out_vsync_q <= 1'b0;
            out_hsync_q <= 1'b0;
            out_de_q    <= 1'b0;
        end else begin
            vsync_q     <= vsync_d;
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
            out_vsync_q <= out_vsync_d;
            out_hsync_q <= out_hsync_d;
            out_de_q    <= out_de_d;
        end
    end

    assign out_R        = out_r_q;
    assign out_G        = out_g_q;
    assign out_B        = out_b_q;
    assign out_vsync    = out_vsync_q;
    assign out_hsync    = out_hsync_q;
    assign out_de       = out_de_q;
    assign cfg_ready    = cfg_ready_q;
    assign swap_pending = swap_pending_q;
    assign active_bank  = active_bank_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Bench for gamma_lut_ctrl: directed scenarios plus randomized traffic, with a
// table-level model of the two banks compared against the DUT every cycle.
module tb_gamma_lut_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_vsync, in_hsync, in_de;
    logic [7:0] in_R, in_G, in_B;
    logic       out_vsync, out_hsync, out_de;
    logic [7:0] out_R, out_G, out_B;
    logic       cfg_wr_en, cfg_commit;
    logic [7:0] cfg_addr, cfg_data;
    logic       cfg_ready, swap_pending, active_bank, init_done;

    always #5 clk = ~clk;

    gamma_lut_ctrl #(.DATA_W(8), .INIT_IDENT(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vsync     (in_vsync),
        .in_hsync     (in_hsync),
        .in_de        (in_de),
        .in_R         (in_R),
        .in_G         (in_G),
        .in_B         (in_B),
        .out_vsync    (out_vsync),
        .out_hsync    (out_hsync),
        .out_de       (out_de),
        .out_R        (out_R),
        .out_G        (out_G),
        .out_B        (out_B),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_commit   (cfg_commit),
        .cfg_ready    (cfg_ready),
        .swap_pending (swap_pending),
        .active_bank  (active_bank),
        .init_done    (init_done)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    // Two tables, which one is live, whether a swap is owed, how far the fill got.
    logic [7:0]  m_tbl [2][256];
    int          m_act;
    bit          m_pend, m_done, m_vprev, m_rise;
    int          m_fill;
    logic [7:0]  m_pr, m_pg, m_pb;
    logic [30:0] m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 256; a++)
                    m_tbl[b][a] = 8'h00;
            m_act = 0; m_pend = 0; m_done = 0; m_vprev = 0; m_fill = 0;
            m_exp = '0;
        end else begin
            m_pr = m_tbl[m_act][in_R];
            m_pg = m_tbl[m_act][in_G];
            m_pb = m_tbl[m_act][in_B];
            m_rise = in_vsync && !m_vprev;
            m_vprev = in_vsync;
            if (!m_done) begin
                m_tbl[0][m_fill] = 8'(m_fill);
                m_tbl[1][m_fill] = 8'(m_fill);
                m_fill++;
                if (m_fill == 256) m_done = 1;
            end else if (!m_pend) begin
                if (cfg_wr_en) m_tbl[1 - m_act][cfg_addr] = cfg_data;
                if (cfg_commit) m_pend = 1;
            end else if (m_rise) begin
                m_act = 1 - m_act;
                m_pend = 0;
            end
            m_exp = {m_pr, m_pg, m_pb, in_vsync, in_hsync, in_de,
                     (m_done && !m_pend), m_pend, (m_act == 1), m_done};
        end
    end

    // Cycle compare of every DUT output against the model.
    logic [30:0] dut_vec;
    always @(negedge clk) begin
        if (chk_en) begin
            dut_vec = {out_R, out_G, out_B, out_vsync, out_hsync, out_de,
                       cfg_ready, swap_pending, active_bank, init_done};
            n_vec++;
            if (dut_vec !== m_exp) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, dut_vec, m_exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        in_vsync = 0; in_hsync = 0; in_de = 0;
        in_R = 0; in_G = 0; in_B = 0;
        cfg_wr_en = 0; cfg_commit = 0; cfg_addr = 0; cfg_data = 0;

        #3 rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", {out_R, cfg_ready, swap_pending, active_bank, init_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: fill takes 256 clocks; unwritten entries read 0 meanwhile.
        in_R = 8'd200;
        n = 0;
        repeat (6) begin @(negedge clk); n++; end
        check("init_unwritten", out_R, 8'h00);
        cfg_wr_en = 1; cfg_addr = 8'd5; cfg_data = 8'h99;
        @(negedge clk); n++;
        cfg_wr_en = 0;
        while (!init_done && n < 400) begin @(negedge clk); n++; end
        check("init_cycles", n, 256);
        check("ready_after_init", cfg_ready, 1);
        in_R = 8'h40;
        @(negedge clk);
        check("t1_identity", out_R, 8'h40);

        // T2: inverse curve into shadow, commit, swap on frame start.
        for (int i = 0; i < 256; i++) begin
            cfg_wr_en = 1; cfg_addr = 8'(i); cfg_data = 8'(255 - i);
            @(negedge clk);
        end
        cfg_wr_en = 0;
        cfg_commit = 1;
        @(negedge clk);
        cfg_commit = 0;
        check("t2_pending", swap_pending, 1);
        check("t2_not_ready", cfg_ready, 0);
        // T4: write during pending is dropped.
        cfg_wr_en = 1; cfg_addr = 8'd5; cfg_data = 8'h99;
        @(negedge clk);
        cfg_wr_en = 0;
        check("t2_no_swap_yet", active_bank, 0);
        in_vsync = 1;
        @(negedge clk);
        check("t2_active1", active_bank, 1);
        check("t2_pend_clear", swap_pending, 0);
        in_G = 8'h10; in_B = 8'd5;
        @(negedge clk);
        check("t2_outG", out_G, 8'hEF);
        check("t4_entry5", out_B, 8'hFA);
        in_vsync = 0;
        @(negedge clk);

        // T3: commit in the same cycle as a frame start.
        cfg_wr_en = 1; cfg_addr = 8'h10; cfg_data = 8'h33;
        @(negedge clk);
        cfg_wr_en = 0;
        in_vsync = 1; cfg_commit = 1;
        @(negedge clk);
        cfg_commit = 0;
        check("t3_pending", swap_pending, 1);
        check("t3_still_bank1", active_bank, 1);
        repeat (3) @(negedge clk);
        check("t3_pending_held", swap_pending, 1);
        in_vsync = 0;
        repeat (2) @(negedge clk);
        in_vsync = 1;
        @(negedge clk);
        check("t3_swapped", active_bank, 0);
        check("t3_pend_clear", swap_pending, 0);
        in_R = 8'h10;
        @(negedge clk);
        check("t3_new_entry", out_R, 8'h33);
        in_vsync = 0;
        @(negedge clk);

        // T6: continuous pixels across a swap.
        cfg_commit = 1;
        @(negedge clk);
        cfg_commit = 0;
        for (int k = 0; k < 20; k++) begin
            in_de = 1;
            in_hsync = (k % 8 == 0);
            in_vsync = (k == 10);
            in_R = (k == 10 || k == 11) ? 8'h22 : 8'($urandom);
            in_G = 8'($urandom); in_B = 8'($urandom);
            @(negedge clk);
            if (k == 10) begin
                check("t6_rise_old", out_R, 8'h22);
                check("t6_vsync_dly", out_vsync, 1);
            end
            if (k == 11) begin
                check("t6_next_new", out_R, 8'hDD);
                check("t6_vsync_low", out_vsync, 0);
            end
        end

        // T5: asynchronous reset while a swap is pending.
        in_R = 8'h22;
        cfg_commit = 1;
        @(negedge clk);
        cfg_commit = 0;
        check("t5_pending", swap_pending, 1);
        check("t5_outR_before", out_R, 8'hDD);
        #2 rst_n = 1'b0;
        #1;
        check("t5_out_zero", out_R, 8'h00);
        check("t5_flags_zero", {cfg_ready, swap_pending, active_bank, init_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(n);
        check("t5_reinit_cycles", n, 256);
        check("t5_bank0", active_bank, 0);
        in_R = 8'hDD;
        @(negedge clk);
        check("t5_identity", out_R, 8'hDD);

        // Randomized traffic, checked by the cycle compare.
        for (int k = 0; k < 2000; k++) begin
            cfg_wr_en = ($urandom_range(0, 1) == 1);
            cfg_addr = 8'($urandom);
            cfg_data = 8'($urandom);
            cfg_commit = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 24) == 0) in_vsync = ~in_vsync;
            in_hsync = ($urandom_range(0, 7) == 0);
            in_de = ($urandom_range(0, 3) != 0);
            in_R = 8'($urandom); in_G = 8'($urandom); in_B = 8'($urandom);
            @(negedge clk);
        end
        cfg_wr_en = 0; cfg_commit = 0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
